// File: rtl/dm_access_pkg.sv
// Shared definitions for the data-memory access unit: size encodings,
// FSM state encoding and default word width.
package dm_access_pkg;

  localparam int unsigned WORD_SIZE = 32;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RSP
  } state_t;

  // Size 11 only reaches the datapath when error checking is off, where it acts as a word.
  function automatic logic size_is_word(input logic [1:0] size);
    return (size == SIZE_W) || (size == 2'b11);
  endfunction

endpackage

// File: rtl/dm_access_unit_lane_align.sv
// dm_lane_align: little-endian lane select with sign/zero extension for loads,
// and lane merge into a captured word for sub-word stores.
module dm_lane_align #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic [1:0]           size,
  input  logic                 is_unsigned,
  input  logic [1:0]           addr_lo,
  input  logic [WORD_SIZE-1:0] rdata,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] load_data,
  output logic [WORD_SIZE-1:0] merge_data
);
  import dm_access_pkg::*;

  logic [4:0]           byte_shift;
  logic [4:0]           half_shift;
  logic [7:0]           byte_lane;
  logic [15:0]          half_lane;
  logic [WORD_SIZE-1:0] byte_mask;
  logic [WORD_SIZE-1:0] half_mask;

  always_comb begin
    byte_shift = {addr_lo, 3'b000};
    // Halfword lane depends on addr[1] only; addr[0] is either an error or ignored.
    half_shift = {addr_lo[1], 4'b0000};
    byte_lane  = 8'(rdata >> byte_shift);
    half_lane  = 16'(rdata >> half_shift);
    byte_mask  = WORD_SIZE'(8'hFF) << byte_shift;
    half_mask  = WORD_SIZE'(16'hFFFF) << half_shift;

    load_data  = rdata;
    merge_data = wdata;
    case (size)
      SIZE_B: begin
        load_data  = {{(WORD_SIZE-8){byte_lane[7] & ~is_unsigned}}, byte_lane};
        merge_data = (rdata & ~byte_mask) | (WORD_SIZE'(wdata[7:0]) << byte_shift);
      end
      SIZE_H: begin
        load_data  = {{(WORD_SIZE-16){half_lane[15] & ~is_unsigned}}, half_lane};
        merge_data = (rdata & ~half_mask) | (WORD_SIZE'(wdata[15:0]) << half_shift);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Load/store access unit in front of a word-wide synchronous data memory.
// Define DM_ACCESS_ERR_EN to enable misalignment and illegal-size error responses.
module dm_access_unit #(
  parameter int unsigned WORD_SIZE = dm_access_pkg::WORD_SIZE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_we,
  input  logic [1:0]           i_req_size,
  input  logic                 i_req_unsigned,
  input  logic [WORD_SIZE-1:0] i_req_addr,
  input  logic [WORD_SIZE-1:0] i_req_wdata,
  output logic                 o_rsp_valid,
  output logic [WORD_SIZE-1:0] o_rsp_rdata,
  output logic                 o_rsp_err,
  output logic [WORD_SIZE-1:0] o_DM_addr,
  output logic [WORD_SIZE-1:0] o_DM_wd,
  output logic                 o_DM_wen,
  output logic                 o_DM_ren,
  input  logic [WORD_SIZE-1:0] i_DM_rd
);
  import dm_access_pkg::*;

  state_t               state;
  logic                 req_we;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [1:0]           req_addr_lo;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 req_err;
  logic [WORD_SIZE-1:0] load_data;
  logic [WORD_SIZE-1:0] merge_data;

`ifdef DM_ACCESS_ERR_EN
  assign req_err = (i_req_size == 2'b11) ||
                   ((i_req_size == SIZE_H) && i_req_addr[0]) ||
                   ((i_req_size == SIZE_W) && (i_req_addr[1:0] != 2'b00));
`else
  assign req_err = 1'b0;
`endif

  dm_lane_align #(
    .WORD_SIZE(WORD_SIZE)
  ) u_lane_align (
    .size       (req_size),
    .is_unsigned(req_unsigned),
    .addr_lo    (req_addr_lo),
    .rdata      (i_DM_rd),
    .wdata      (req_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_req_ready  <= 1'b1;
      o_DM_ren     <= 1'b0;
      o_DM_wen     <= 1'b0;
      o_DM_addr    <= '0;
      o_DM_wd      <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_rdata  <= '0;
      o_rsp_err    <= 1'b0;
      req_we       <= 1'b0;
      req_size     <= '0;
      req_unsigned <= 1'b0;
      req_addr_lo  <= '0;
      req_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            req_we       <= i_req_we;
            req_size     <= i_req_size;
            req_unsigned <= i_req_unsigned;
            req_addr_lo  <= i_req_addr[1:0];
            req_wdata    <= i_req_wdata;
            o_req_ready  <= 1'b0;
            o_DM_addr    <= {i_req_addr[WORD_SIZE-1:2], 2'b00};
            if (req_err) begin
              state       <= RSP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= '0;
            end else if (i_req_we && size_is_word(i_req_size)) begin
              state    <= WR;
              o_DM_wen <= 1'b1;
              o_DM_wd  <= i_req_wdata;
            end else begin
              state    <= RD;
              o_DM_ren <= 1'b1;
            end
          end
        end
        RD: begin
          o_DM_ren <= 1'b0;
          state    <= CAP;
        end
        // Read data is valid here; it is consumed straight into the response or write word.
        CAP: begin
          if (req_we) begin
            state    <= WR;
            o_DM_wen <= 1'b1;
            o_DM_wd  <= merge_data;
          end else begin
            state       <= RSP;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= load_data;
          end
        end
        WR: begin
          o_DM_wen    <= 1'b0;
          state       <= RSP;
          o_rsp_valid <= 1'b1;
          o_rsp_rdata <= '0;
        end
        RSP: begin
          o_rsp_valid <= 1'b0;
          o_rsp_err   <= 1'b0;
          o_rsp_rdata <= '0;
          o_req_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_DM_ren    <= 1'b0;
          o_DM_wen    <= 1'b0;
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Load/store access unit between the core's memory-request port and the word-wide synchronous data memory. It accepts one byte, halfword or word request at a time. Loads are returned aligned and sign- or zero-extended. Sub-word stores are built as read-modify-write, because the data memory has only a whole-word write enable.

## Interface
Parameters:
- WORD_SIZE, 32, data and address width.

Ports:
- i_clk  in  1  single clock, all state on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  request present; held stable until accepted.
- o_req_ready  out  1  high only in IDLE.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- i_req_unsigned  in  1  zero-extend loads.
- i_req_addr  in  WORD_SIZE  byte address.
- i_req_wdata  in  WORD_SIZE  store data, right-justified.
- o_rsp_valid  out  1  single-cycle completion pulse; no backpressure.
- o_rsp_rdata  out  WORD_SIZE  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  misaligned or illegal size.
- o_DM_addr  out  WORD_SIZE  word-aligned address {addr[31:2],2'b00}.
- o_DM_wd  out  WORD_SIZE  write word.
- o_DM_wen  out  1  write strobe.
- o_DM_ren  out  1  read strobe.
- i_DM_rd  in  WORD_SIZE  read data, valid one cycle after o_DM_ren.

## Operation
- FSM states: IDLE, RD, CAP, WR, RSP. A request is accepted on i_req_valid && o_req_ready. The request fields are registered at acceptance.
- Transitions out of IDLE on accept:
  - error → RSP
  - word store → WR
  - load or sub-word store → RD
- Other transitions:
  - RD → CAP
  - CAP → RSP for a load
  - CAP → WR for a sub-word store
  - WR → RSP
  - RSP → IDLE
- RD drives o_DM_ren=1. CAP registers i_DM_rd. WR drives o_DM_wen=1 with o_DM_wd. RSP drives o_rsp_valid=1.
- Byte lanes are little-endian and selected by addr[1:0]; a halfword uses addr[1].
- Load data: the selected lane, sign-extended from bit 7 or 15 unless unsigned. A word load passes through unchanged.
- Store merge: the captured word with the selected lane replaced by wdata[7:0] or wdata[15:0]. A word store writes wdata directly with no read.
- Error conditions: half with addr[0]=1, word with addr[1:0]≠0, or size 11. An error performs no memory access and sets o_rsp_err=1 with o_rsp_rdata=0.
- i_req_valid outside IDLE is ignored.

## Timing
- Reset values: state IDLE, and all outputs 0 except o_req_ready=1.
- All outputs are registered or decoded from state. There is no combinational path from request inputs to outputs other than o_req_ready.
- Latency, with acceptance at cycle 0 and o_rsp_valid at cycle N:
  - error: 1
  - word store: 2 (wen in cycle 1)
  - load: 3 (ren in cycle 1, capture in cycle 2)
  - sub-word store: 4 (ren 1, capture 2, wen 3)
- Back-to-back requests: the next accept is possible in the cycle after RSP.
- Reset mid-operation: the next edge forces IDLE and clears the strobes. No response is issued.
  - A wen already presented in the cycle where reset is sampled completes, since memory samples the same edge.
  - Reset during RD or CAP guarantees no write.

## Configuration
- DM_ACCESS_ERR_EN defined:
  - Misalignment and illegal-size checks are active, as above.
- DM_ACCESS_ERR_EN undefined:
  - o_rsp_err is tied 0.
  - Low address bits below the access size are ignored: half uses addr[1] only, word ignores addr[1:0].
  - Size 11 is treated as word.
  - Every request performs its memory access.

## Structure
- Shared package dm_access_pkg holds:
  - the size encodings SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - the FSM state encoding;
  - WORD_SIZE.
- One combinational sub-module, dm_lane_align, holds the lane select, sign/zero extension and store merge.
- The FSM, request register and memory strobes live in dm_access_unit.

## Test plan
Memory word 0x10 preloaded with 0x8899AABB.
- LB, addr 0x11, signed → ren in cycle 1, o_rsp_valid in cycle 3, rdata 0xFFFFFFAA, err 0.
- LHU, addr 0x12 → rdata 0x00008899 in cycle 3.
- SB, addr 0x13, wdata 0x000000CC → ren in cycle 1, wen in cycle 3 with o_DM_wd 0xCC99AABB at o_DM_addr 0x10, rsp in cycle 4; a following LW returns 0xCC99AABB.
- SW, addr 0x10, wdata 0x12345678 → wen in cycle 1, no ren, rsp in cycle 2.
- LW, addr 0x12:
  - with DM_ACCESS_ERR_EN: no ren/wen, rsp in cycle 1 with err=1, rdata 0.
  - without: reads 0x10, returns 0x8899AABB.
- SH to 0x10 with i_rst asserted during CAP → o_DM_wen never rises, no o_rsp_valid, o_req_ready=1 the cycle after the reset edge, memory unchanged.
